// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types, parameter defaults and the feature default for the two-master memory bus arbiter.
// The optional slave-ack watchdog is enabled by defining BUS_TIMEOUT_EN (off by default).
package mem_bus_arbiter_pkg;

  localparam int unsigned AddrWDefault         = 32;
  localparam int unsigned DataWDefault         = 32;
  localparam int unsigned FairMaxDefault       = 4;
  localparam int unsigned TimeoutCyclesDefault = 255;

`ifdef BUS_TIMEOUT_EN
  localparam bit BusTimeoutEn = 1'b1;
`else
  localparam bit BusTimeoutEn = 1'b0;
`endif

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StBusyM0 = 2'd1,
    StBusyM1 = 2'd2
  } arb_state_e;

  function automatic int unsigned sat_inc(input int unsigned value, input int unsigned limit);
    return (value >= limit) ? limit : value + 1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch master (m0), data master (m1), shared slave and pipeline-control signals.
// Modports: master (pipeline side), slave (memory side), arb (the arbiter itself).
interface mem_bus_arbiter_if
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned DATA_W = DataWDefault
);

  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m0_err;

  logic              m1_req;
  logic              m1_we;
  logic [3:0]        m1_sel;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
  logic              m1_err;

  logic              s_req;
  logic              s_we;
  logic [3:0]        s_sel;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata;
  logic              s_ack;

  logic              flush;
  logic              stallreq_if;
  logic              stallreq_mem;

  modport master (
    output m0_req, m0_addr, m1_req, m1_we, m1_sel, m1_addr, m1_wdata, flush,
    input  m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err, stallreq_if, stallreq_mem
  );

  modport slave (
    input  s_req, s_we, s_sel, s_addr, s_wdata,
    output s_rdata, s_ack
  );

  modport arb (
    input  m0_req, m0_addr, m1_req, m1_we, m1_sel, m1_addr, m1_wdata, flush, s_rdata, s_ack,
    output m0_rdata, m0_ack, m0_err, m1_rdata, m1_ack, m1_err,
    output s_req, s_we, s_sel, s_addr, s_wdata, stallreq_if, stallreq_mem
  );

endinterface

// File: rtl/bus_watchdog.sv
// Slave-ack watchdog: armed by start, counts armed cycles, flags expired in the LIMIT-th one.
// Only present when BUS_TIMEOUT_EN is defined.
`ifdef BUS_TIMEOUT_EN
module bus_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CntW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic            armed_q;
  logic [CntW-1:0] cnt_q;
  logic            at_limit;

  // cnt_q is k-1 during the k-th armed cycle
  assign at_limit = (cnt_q == CntW'(LIMIT - 1));
  assign expired  = armed_q & at_limit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else if (clear) begin
      armed_q <= 1'b0;
      cnt_q   <= '0;
    end else if (start) begin
      armed_q <= 1'b1;
      cnt_q   <= '0;
    end else if (armed_q && !at_limit) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Two-master (fetch m0 / data m1) arbiter onto one slave, with fairness and flush discard.
// Define BUS_TIMEOUT_EN to add the slave-ack watchdog that terminates hung transfers with err.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = AddrWDefault,
  parameter int unsigned DATA_W         = DataWDefault,
  parameter int unsigned FAIR_MAX       = FairMaxDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input logic             clk,
  input logic             rst,
  mem_bus_arbiter_if.arb  bus
);

  localparam int unsigned FairW = $clog2(FAIR_MAX + 1);

  arb_state_e       state_q;
  logic [FairW-1:0] fair_q;
  logic             discard_q;

  logic             is_m0;
  logic             is_m1;
  logic             busy;
  logic             grant_m0;
  logic             grant_m1;
  logic             expired;
  logic             done;
  logic             m0_ack;
  logic             m1_ack;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign is_m0 = (state_q == StBusyM0);
  assign is_m1 = (state_q == StBusyM1);
  assign busy  = is_m0 | is_m1;

  // A flushed fetch is never granted; m0 beats m1 only once m1 has had FAIR_MAX turns in a row
  assign grant_m0 = bus.m0_req & ~bus.flush & (~bus.m1_req | (fair_q == FairW'(FAIR_MAX)));
  assign grant_m1 = bus.m1_req & ~grant_m0;

`ifdef BUS_TIMEOUT_EN
  bus_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .start   ((state_q == StIdle) & (grant_m0 | grant_m1)),
    .clear   (done),
    .expired (expired)
  );

  // Error shares the last s_req cycle with where an ack would have been; ack wins a tie
  assign bus.m0_err = is_m0 & expired & ~bus.s_ack & ~discard_q & ~bus.flush;
  assign bus.m1_err = is_m1 & expired & ~bus.s_ack;
`else
  assign expired    = 1'b0;
  assign bus.m0_err = 1'b0;
  assign bus.m1_err = 1'b0;
`endif

  assign done = busy & (bus.s_ack | expired);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      fair_q    <= '0;
      discard_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_m0) begin
            state_q <= StBusyM0;
            fair_q  <= '0;
          end else if (grant_m1) begin
            state_q <= StBusyM1;
            fair_q  <= bus.m0_req ? FairW'(sat_inc(32'(fair_q), FAIR_MAX)) : '0;
          end else if (!bus.m0_req) begin
            fair_q <= '0;
          end
        end
        StBusyM0: begin
          if (done) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
          end else if (bus.flush) begin
            discard_q <= 1'b1;
          end
        end
        StBusyM1: begin
          if (done) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // A flush arriving in the ack cycle itself also suppresses the fetch completion
  assign m0_ack = is_m0 & bus.s_ack & ~discard_q & ~bus.flush;
  assign m1_ack = is_m1 & bus.s_ack;

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (is_m0) begin
      addr_mux = bus.m0_addr;
    end else if (is_m1) begin
      addr_mux  = bus.m1_addr;
      wdata_mux = bus.m1_wdata;
    end
  end

  assign bus.s_req   = busy;
  assign bus.s_we    = is_m1 & bus.m1_we;
  assign bus.s_sel   = is_m1 ? bus.m1_sel : (is_m0 ? 4'b1111 : 4'b0000);
  assign bus.s_addr  = addr_mux;
  assign bus.s_wdata = wdata_mux;

  assign bus.m0_ack   = m0_ack;
  assign bus.m1_ack   = m1_ack;
  assign bus.m0_rdata = m0_ack ? bus.s_rdata : '0;
  assign bus.m1_rdata = m1_ack ? bus.s_rdata : '0;

  assign bus.stallreq_if  = ~rst & bus.m0_req & ~m0_ack;
  assign bus.stallreq_mem = ~rst & bus.m1_req & ~m1_ack;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: directed stimulus pushes expected responses, a monitor
// pops them on every ack/err. Covers the timeout path when built with BUS_TIMEOUT_EN.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int unsigned Tmo = 8;

  typedef struct {
    int unsigned master;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_bus_arbiter #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .FAIR_MAX       (4),
    .TIMEOUT_CYCLES (Tmo)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned ack_delay = 1;
  int unsigned slave_cnt = 0;
  logic [31:0] slave_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic expect_resp(input int unsigned m, input bit e, input logic [31:0] d);
    exp_t x;
    x.master = m;
    x.err    = e;
    x.rdata  = d;
    exp_q.push_back(x);
  endtask

  task automatic wait_resp(input string name, input int unsigned budget);
    for (int i = 0; i < int'(budget); i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d responses outstanding after %0d cycles, expected 0", name,
               exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // Slave model: acks ack_delay cycles after s_req first appears, returning slave_data
  initial begin
    bus.s_ack   = 1'b0;
    bus.s_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.s_ack   = 1'b0;
      bus.s_rdata = '0;
      if (bus.s_req === 1'b1) begin
        if (slave_cnt == ack_delay) begin
          bus.s_ack   = 1'b1;
          bus.s_rdata = slave_data;
        end
        slave_cnt++;
      end else begin
        slave_cnt = 0;
      end
    end
  end

  // Monitor: every response the DUT presents must match the head of the scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if ((bus.m0_ack | bus.m0_err | bus.m1_ack | bus.m1_err) === 1'b1) begin
        int unsigned got_m;
        bit          got_e;
        logic [31:0] got_d;
        exp_t        e;
        got_m = (bus.m1_ack | bus.m1_err) ? 1 : 0;
        got_e = bus.m0_err | bus.m1_err;
        got_d = got_m ? bus.m1_rdata : bus.m0_rdata;
        check("sb_single_master", 32'((bus.m0_ack | bus.m0_err) & (bus.m1_ack | bus.m1_err)), 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got response master=%0d err=%0d, expected none",
                   got_m, got_e);
        end else begin
          e = exp_q.pop_front();
          check("sb_master", got_m, e.master);
          check("sb_kind_err", 32'(got_e), 32'(e.err));
          check("sb_rdata", got_d, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, expected finish", $time);
    $fatal(1, "time limit");
  end

  initial begin
    bus.m0_req   = 1'b1;
    bus.m0_addr  = '0;
    bus.m1_req   = 1'b1;
    bus.m1_we    = 1'b0;
    bus.m1_sel   = 4'hF;
    bus.m1_addr  = '0;
    bus.m1_wdata = '0;
    bus.flush    = 1'b0;
    $display("timeout feature enabled: %0d", BusTimeoutEn);

    // Reset state, with both requests up so the stall gating is exercised
    @(negedge clk);
    check("rst_s_req", 32'(bus.s_req), 0);
    check("rst_stall_if", 32'(bus.stallreq_if), 0);
    check("rst_stall_mem", 32'(bus.stallreq_mem), 0);
    check("rst_acks", {30'd0, bus.m0_ack, bus.m1_ack}, 0);
    check("rst_s_addr", bus.s_addr, 0);
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;

    // Single fetch, slave acks one cycle after s_req
    slave_data = 32'h3C01_1234;
    ack_delay  = 1;
    @(posedge clk);
    #1;
    bus.m0_req  = 1'b1;
    bus.m0_addr = 32'h0000_0100;
    expect_resp(0, 1'b0, 32'h3C01_1234);
    @(negedge clk);
    check("t1_stall_if_c0", 32'(bus.stallreq_if), 1);
    check("t1_s_req_c0", 32'(bus.s_req), 0);
    @(negedge clk);
    check("t1_s_req_c1", 32'(bus.s_req), 1);
    check("t1_s_addr_c1", bus.s_addr, 32'h0000_0100);
    check("t1_rdata_zero_c1", bus.m0_rdata, 0);
    @(negedge clk);
    check("t1_m0_ack_c2", 32'(bus.m0_ack), 1);
    check("t1_stall_if_c2", 32'(bus.stallreq_if), 0);
    @(posedge clk);
    #1 bus.m0_req = 1'b0;
    wait_resp("t1_fetch", 4);

    // Both masters held, immediate acks: fairness gives M1 x4 then M0
    slave_data = 32'h1111_2222;
    ack_delay  = 0;
    @(posedge clk);
    #1;
    bus.m0_req  = 1'b1;
    bus.m0_addr = 32'h0000_0200;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) expect_resp(1, 1'b0, 32'h1111_2222);
    expect_resp(0, 1'b0, 32'h1111_2222);
    wait_resp("t2_fair_order", 30);
    @(posedge clk);
    #1;
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;

    // Flush during BUSY_M0: fetch completes on the slave silently, then M1 is granted
    slave_data = 32'h5555_AAAA;
    ack_delay  = 3;
    @(posedge clk);
    #1;
    bus.m0_req  = 1'b1;
    bus.m0_addr = 32'h0000_0800;
    @(posedge clk);
    #1;
    check("t3_busy_m0", 32'(bus.s_req), 1);
    check("t3_busy_addr", bus.s_addr, 32'h0000_0800);
    bus.flush   = 1'b1;
    bus.m0_req  = 1'b0;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 32'h0000_0400;
    expect_resp(1, 1'b0, 32'h5555_AAAA);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    repeat (3) @(negedge clk);
    check("t3_slave_ack", 32'(bus.s_ack), 1);
    check("t3_no_m0_ack", 32'(bus.m0_ack), 0);
    @(negedge clk);
    check("t3_idle_gap", 32'(bus.s_req), 0);
    @(negedge clk);
    check("t3_m1_granted", 32'(bus.s_req), 1);
    check("t3_m1_addr", bus.s_addr, 32'h0000_0400);
    wait_resp("t3_after_flush", 10);
    @(posedge clk);
    #1 bus.m1_req = 1'b0;

    // M1 byte-lane write
    slave_data = 32'h0BAD_F00D;
    ack_delay  = 2;
    @(posedge clk);
    #1;
    bus.m1_req   = 1'b1;
    bus.m1_we    = 1'b1;
    bus.m1_sel   = 4'b0011;
    bus.m1_addr  = 32'h0000_0500;
    bus.m1_wdata = 32'hDEAD_BEEF;
    expect_resp(1, 1'b0, 32'h0BAD_F00D);
    @(negedge clk);
    check("t4_stall_mem_c0", 32'(bus.stallreq_mem), 1);
    @(negedge clk);
    check("t4_s_we", 32'(bus.s_we), 1);
    check("t4_s_sel", 32'(bus.s_sel), 32'h3);
    check("t4_s_wdata", bus.s_wdata, 32'hDEAD_BEEF);
    check("t4_s_addr", bus.s_addr, 32'h0000_0500);
    @(negedge clk);
    check("t4_stall_mem_c2", 32'(bus.stallreq_mem), 1);
    @(negedge clk);
    check("t4_m1_ack_c3", 32'(bus.m1_ack), 1);
    check("t4_stall_mem_ack", 32'(bus.stallreq_mem), 0);
    @(posedge clk);
    #1;
    bus.m1_req = 1'b0;
    bus.m1_we  = 1'b0;
    bus.m1_sel = 4'hF;
    wait_resp("t4_write", 3);

    // Reset in the middle of BUSY_M1, then the same request completes
    ack_delay = 1000;
    @(posedge clk);
    #1;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 32'h0000_0600;
    @(posedge clk);
    #1 check("t5_busy", 32'(bus.s_req), 1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("t5_rst_s_req", 32'(bus.s_req), 0);
    check("t5_rst_s_addr", bus.s_addr, 0);
    check("t5_rst_stall_mem", 32'(bus.stallreq_mem), 0);
    check("t5_rst_m1_ack", 32'(bus.m1_ack), 0);
    ack_delay  = 0;
    slave_data = 32'h7777_0001;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    expect_resp(1, 1'b0, 32'h7777_0001);
    wait_resp("t5_reissue", 6);
    @(posedge clk);
    #1 bus.m1_req = 1'b0;

`ifdef BUS_TIMEOUT_EN
    // Slave never acks: err in the Tmo-th BUSY cycle, then s_req drops
    ack_delay = 1000;
    @(posedge clk);
    #1;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 32'h0000_0700;
    expect_resp(1, 1'b1, 32'h0);
    @(negedge clk);
    for (int k = 1; k <= int'(Tmo); k++) begin
      @(negedge clk);
      check("t6_s_req_busy", 32'(bus.s_req), 1);
      check("t6_m1_err", 32'(bus.m1_err), (k == int'(Tmo)) ? 1 : 0);
      check("t6_m1_ack", 32'(bus.m1_ack), 0);
    end
    @(posedge clk);
    #1 bus.m1_req = 1'b0;
    @(negedge clk);
    check("t6_s_req_dropped", 32'(bus.s_req), 0);
    wait_resp("t6_timeout", 2);
`else
    // Without the watchdog a hung slave just holds the grant
    ack_delay = 1000;
    @(posedge clk);
    #1;
    bus.m1_req  = 1'b1;
    bus.m1_addr = 32'h0000_0900;
    repeat (20) @(negedge clk);
    check("t6_hang_s_req", 32'(bus.s_req), 1);
    check("t6_hang_no_err", 32'(bus.m1_err), 0);
    check("t6_hang_stall_mem", 32'(bus.stallreq_mem), 1);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    bus.m1_req = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_after_rst_idle", 32'(bus.s_req), 0);
`endif

    @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, 32, address width of master and slave ports.
REQ-002 Parameter DATA_W, 32, data width of master and slave ports.
REQ-003 Parameter FAIR_MAX, 4, number of consecutive M1 grants allowed while M0 waits.
REQ-004 Parameter TIMEOUT_CYCLES, 255, slave-ack watchdog limit; used only with BUS_TIMEOUT_EN.
REQ-005 clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 m0_req / m0_addr  input  1 / ADDR_W  instruction-fetch master request and address (read-only).
REQ-008 m0_rdata / m0_ack / m0_err  output  DATA_W / 1 / 1  fetch read data, one-cycle completion pulse, one-cycle error pulse.
REQ-009 m1_req / m1_we / m1_sel / m1_addr / m1_wdata  input  1 / 1 / 4 / ADDR_W / DATA_W  data-access master request.
REQ-010 m1_rdata / m1_ack / m1_err  output  DATA_W / 1 / 1  data-access response, same rules as M0.
REQ-011 s_req / s_we / s_sel / s_addr / s_wdata  output  1 / 1 / 4 / ADDR_W / DATA_W  shared slave request.
REQ-012 s_rdata / s_ack  input  DATA_W / 1  slave read data and one-cycle completion pulse.
REQ-013 flush  input  1  pipeline flush (exception/eret); abandons the pending fetch.
REQ-014 stallreq_if / stallreq_mem  output  1 / 1  stall requests to pipeline control.

Function
REQ-015 States IDLE, BUSY_M0, BUSY_M1; exactly one active.
REQ-016 IDLE: m1_req wins over m0_req, except that m0 wins when the fair counter equals FAIR_MAX and both request.
REQ-017 IDLE with flush=1: m0_req is not granted that cycle; m1 arbitration is unaffected.
REQ-018 Grant is registered: request sampled at edge N moves the FSM to BUSY_Mx at N; s_req=1 with the granted master's signals muxed combinationally in the following cycle.
REQ-019 BUSY_Mx: s_req held until s_ack=1; in the s_ack cycle mx_ack=1, mx_rdata=s_rdata, and the FSM returns to IDLE at the next edge.
REQ-020 Minimum latency: ack in the second cycle after req assertion; back-to-back grants insert one IDLE cycle.
REQ-021 Masters hold req and payload stable until ack/err; the arbiter never drives ack to a non-granted master.
REQ-022 Flush in BUSY_M0 sets a discard flag; the slave transaction completes, m0_ack is suppressed, and the flag clears on return to IDLE.
REQ-023 Flush has no effect on BUSY_M1.
REQ-024 Fair counter (saturating, 0..FAIR_MAX): +1 on each M1 grant while m0_req=1; cleared on M0 grant or when m0_req=0 in IDLE.
REQ-025 stallreq_if = m0_req & ~m0_ack; stallreq_mem = m1_req & ~m1_ack; both forced 0 while rst=1.
REQ-026 m*_rdata = 0 when the corresponding ack is 0.

Reset
REQ-027 rst=1 immediately forces IDLE, discard=0, fair counter=0, watchdog=0, s_req=0, all acks/errs/stalls=0, all data outputs=0.
REQ-028 Reset mid-transaction abandons it; no ack or err is issued for it after reset release.

Configuration
REQ-029 Macro BUS_TIMEOUT_EN defined: watchdog counts BUSY cycles; at TIMEOUT_CYCLES without s_ack, s_req drops, granted mx_err pulses for one cycle (no ack), FSM returns to IDLE; a discarded M0 times out silently.
REQ-030 Macro BUS_TIMEOUT_EN undefined: no watchdog logic; BUSY waits indefinitely; m0_err=m1_err=0.

Structure
REQ-031 State encodings, parameter defaults and the BUS_TIMEOUT_EN default live in the shared defines package.
REQ-032 Watchdog is sub-module bus_watchdog (clk, rst, start, clear, expired), instantiated only under BUS_TIMEOUT_EN.

Verification
REQ-033 m0_req only, slave acks 1 cycle after s_req -> m0_ack in cycle 2, m0_rdata=s_rdata (e.g. 0x3C011234).
REQ-034 m0_req and m1_req both held, FAIR_MAX=4, slave acks immediately -> grant order M1,M1,M1,M1,M0.
REQ-035 flush in BUSY_M0, slave acks 3 cycles later -> no m0_ack, s_req drops, next IDLE grants M1.
REQ-036 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks M1 -> m1_err pulse after 8 BUSY cycles, m1_ack stays 0.
REQ-037 rst asserted during BUSY_M1 -> all outputs 0 same cycle; after release, m1_req re-issue completes normally.
REQ-038 m1 write (we=1, sel=4'b0011, wdata=0xDEADBEEF) -> s_we/s_sel/s_wdata match during s_req; stallreq_mem=1 until the ack cycle.
